// File: rtl/data_port_arb_pkg.sv
// Shared types and constants for the data port arbiter.
// Optional feature macro: DATA_PORT_ARB_STATS_EN (per-requester beat counters).
package data_port_arb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    localparam int DEF_N_REQ     = 4;
    localparam int DEF_DATA_W    = 8;
    localparam int DEF_MAX_BURST = 4;
    localparam int STAT_W        = 16;
    localparam int BEAT_CNT_W    = 4;

    // Index width that stays legal for a single requester.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/data_port_arb_rr_picker.sv
// Combinational round-robin picker: first set request at or after rr_ptr, wrapping.
module rr_picker
    import data_port_arb_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ
) (
    input  logic [N_REQ-1:0]        req,
    input  logic [idx_w(N_REQ)-1:0] rr_ptr,
    output logic [idx_w(N_REQ)-1:0] winner,
    output logic                    found
);

    localparam int IDX_W = idx_w(N_REQ);

    int unsigned idx;

    // Scan from the farthest candidate back to rr_ptr so the nearest one wins.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx = (int'(rr_ptr) + i) % N_REQ;
            if (req[IDX_W'(idx)]) begin
                winner = IDX_W'(idx);
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/data_port_arb.sv
// Round-robin arbiter sharing one registered data port among N_REQ bursting requesters.
// Optional feature macro: DATA_PORT_ARB_STATS_EN (per-requester beat counters).
//
// state | meaning
// IDLE  | no owner; pick a winner, no beat moves this cycle
// BURST | grant_id owns the port until last beat or MAX_BURST beats
module data_port_arb
    import data_port_arb_pkg::*;
#(
    parameter int N_REQ     = DEF_N_REQ,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int MAX_BURST = DEF_MAX_BURST
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [N_REQ-1:0]                   req_valid,
    input  logic [N_REQ-1:0][DATA_W-1:0]       req_data,
    input  logic [N_REQ-1:0]                   req_last,
    output logic [N_REQ-1:0]                   req_ready,
    output logic                               out_valid,
    output logic [DATA_W-1:0]                  out_data,
    input  logic                               out_ready,
    output logic [idx_w(N_REQ)-1:0]            grant_id,
    output logic                               busy,
    output logic [N_REQ-1:0][STAT_W-1:0]       stat_beats
);

    localparam int IDX_W = idx_w(N_REQ);

    arb_state_e              state, state_nxt;
    logic [IDX_W-1:0]        rr_ptr;
    logic [BEAT_CNT_W-1:0]   beat_cnt;
    logic [IDX_W-1:0]        pick_winner;
    logic                    pick_found;
    logic                    xfer;
    logic                    burst_end;

    rr_picker #(.N_REQ(N_REQ)) u_picker (
        .req    (req_valid),
        .rr_ptr (rr_ptr),
        .winner (pick_winner),
        .found  (pick_found)
    );

    // Ready is withheld while reset is asserted so no beat is accepted that cycle.
    always_comb begin
        req_ready = '0;
        if (state == BURST && !rst) begin
            req_ready[grant_id] = !out_valid || out_ready;
        end
    end

    assign xfer      = (state == BURST) && req_valid[grant_id] && req_ready[grant_id];
    assign burst_end = xfer && (req_last[grant_id] ||
                                beat_cnt == BEAT_CNT_W'(MAX_BURST - 1));
    assign busy      = (state == BURST);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick_found) state_nxt = BURST;
            BURST:   if (burst_end)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr    <= '0;
            beat_cnt  <= '0;
            grant_id  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            if (xfer) begin
                out_valid <= 1'b1;
                out_data  <= req_data[grant_id];
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            if (state == IDLE && pick_found) begin
                grant_id <= pick_winner;
                beat_cnt <= '0;
            end else if (xfer) begin
                beat_cnt <= beat_cnt + BEAT_CNT_W'(1);
            end

            if (burst_end) begin
                rr_ptr <= (grant_id == IDX_W'(N_REQ - 1)) ? '0 : grant_id + IDX_W'(1);
            end
        end
    end

`ifdef DATA_PORT_ARB_STATS_EN
    logic [N_REQ-1:0][STAT_W-1:0] stat_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_cnt <= '0;
        end else if (xfer && stat_cnt[grant_id] != {STAT_W{1'b1}}) begin
            stat_cnt[grant_id] <= stat_cnt[grant_id] + STAT_W'(1);
        end
    end

    assign stat_beats = stat_cnt;
`else
    assign stat_beats = '0;
`endif

endmodule
